// File: rtl/i2c_master_ctrl.sv
// I2C initiator for single-register write (S,aW,idx,data,P) and read (S,aW,idx,Sr,aR,data+NACK,P) frames.
// Open-drain SCL/SDA via oe/out pairs; bus timing derived from a CLK_DIV quarter-period tick.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [6:0] dev_addr_i,
    input  logic [7:0] index_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       scl_out_o,
    output logic       scl_oe_o,
    input  logic       sda_in_i,
    output logic       sda_out_o,
    output logic       sda_oe_o
);

    typedef enum logic [2:0] {
        IDLE, START, TX, RXACK, RSTART, RX, MACK, STOP
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ack_bit_q, ack_bit_d;
    logic        ack_err_q, ack_err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;
    logic [1:0]  sync_q;

    logic sda_s, tick, sample, slot_end, accept;

    assign sda_s    = sync_q[1];
    assign tick     = (div_q == DIV_LAST);
    assign sample   = tick && (qtr_q == 2'd2);
    assign slot_end = tick && (qtr_q == 2'd3);
    assign accept   = (state_q == IDLE) && !done_q && start_i;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        sel_d     = sel_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        index_d   = index_q;
        wdata_d   = wdata_q;
        ack_bit_d = ack_bit_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        scl_oe_d  = 1'b0;
        sda_oe_d  = 1'b0;

        if (state_q == IDLE) begin
            div_d = '0;
            qtr_d = '0;
        end else if (tick) begin
            div_d = '0;
            qtr_d = qtr_q + 2'd1;
        end else begin
            div_d = div_q + 16'd1;
        end

        // Line levels are registered, so pins trail the quarter counter by one clk.
        // In Q0 of a data slot SDA keeps its previous level; new bits appear at Q1.
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rw_d      = rw_i;
                    addr_d    = dev_addr_i;
                    index_d   = index_i;
                    wdata_d   = wdata_i;
                    ack_err_d = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                sda_oe_d = qtr_q[1];
                if (slot_end) begin
                    shift_d = {addr_q, 1'b0};
                    bit_d   = '0;
                    sel_d   = 2'd0;
                    state_d = TX;
                end
            end
            TX: begin
                scl_oe_d = ~qtr_q[1];
                sda_oe_d = (qtr_q == 2'd0) ? sda_oe_q : ~shift_q[7];
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = RXACK;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            RXACK: begin
                scl_oe_d = ~qtr_q[1];
                sda_oe_d = (qtr_q == 2'd0) ? sda_oe_q : 1'b0;
                if (sample) ack_bit_d = sda_s;
                if (slot_end) begin
                    bit_d = '0;
                    if (ack_bit_q) begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end else begin
                        case (sel_q)
                            2'd0: begin
                                shift_d = index_q;
                                sel_d   = 2'd1;
                                state_d = TX;
                            end
                            2'd1: begin
                                if (rw_q) begin
                                    state_d = RSTART;
                                end else begin
                                    shift_d = wdata_q;
                                    sel_d   = 2'd2;
                                    state_d = TX;
                                end
                            end
                            2'd2:    state_d = STOP;
                            default: state_d = RX;
                        endcase
                    end
                end
            end
            RSTART: begin
                scl_oe_d = ~qtr_q[1];
                sda_oe_d = (qtr_q == 2'd3);
                if (slot_end) begin
                    shift_d = {addr_q, 1'b1};
                    bit_d   = '0;
                    sel_d   = 2'd3;
                    state_d = TX;
                end
            end
            RX: begin
                scl_oe_d = ~qtr_q[1];
                if (sample) shift_d = {shift_q[6:0], sda_s};
                if (slot_end) begin
                    if (bit_q == 3'd7) state_d = MACK;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            MACK: begin
                scl_oe_d = ~qtr_q[1];
                if (slot_end) begin
                    rdata_d = shift_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                scl_oe_d = ~qtr_q[1];
                sda_oe_d = (qtr_q != 2'd3);
                if (slot_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            sel_q     <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            index_q   <= '0;
            wdata_q   <= '0;
            ack_bit_q <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            sync_q    <= '1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            sel_q     <= sel_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            index_q   <= index_d;
            wdata_q   <= wdata_d;
            ack_bit_q <= ack_bit_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
            sync_q    <= {sync_q[0], sda_in_i};
        end
    end

    assign rdata_o   = rdata_q;
    assign busy_o    = (state_q != IDLE) || done_q || accept;
    assign done_o    = done_q;
    assign ack_err_o = ack_err_q;
    assign scl_out_o = 1'b0;
    assign scl_oe_o  = scl_oe_q;
    assign sda_out_o = 1'b0;
    assign sda_oe_o  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: register-slave model on the bus plus queues of expected bus events and results.
module tb_i2c_master_ctrl;

    localparam int unsigned DIV = 4;
    localparam int EV_S  = 256;
    localparam int EV_SR = 257;
    localparam int EV_P  = 258;
    localparam logic [6:0] SLV = 7'h72;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       rw_i = 1'b0;
    logic [6:0] dev_addr_i = '0;
    logic [7:0] index_i = '0;
    logic [7:0] wdata_i = '0;
    logic [7:0] rdata_o;
    logic       busy_o, done_o, ack_err_o;
    logic       scl_out_o, scl_oe_o, sda_out_o, sda_oe_o;
    logic       slave_pull = 1'b0;
    logic       sda_line;

    assign sda_line = ~(sda_oe_o | slave_pull);

    i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rw_i(rw_i),
        .dev_addr_i(dev_addr_i), .index_i(index_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o), .ack_err_o(ack_err_o),
        .scl_out_o(scl_out_o), .scl_oe_o(scl_oe_o), .sda_in_i(sda_line),
        .sda_out_o(sda_out_o), .sda_oe_o(sda_oe_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int accepted = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int         lat;
        logic       ack;
        logic [7:0] rd;
        int         acc;
    } res_t;

    int   ev_q[$];
    res_t res_q[$];

    task automatic bus_ev(input int ev);
        int e;
        chk("ev_q_empty", ev_q.size() == 0, 0);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            chk("bus_ev", ev, e);
        end
    endtask

    // Slave: address 0x72, registers 0x40..0x53 ACKed, others NACKed.
    logic [7:0] regs [256];
    int         sl_mode = 0;   // 0 idle, 1 receive, 2 send, 3 wait-for-stop
    int         sl_bit = 0;
    int         sl_byte = 0;
    logic [7:0] sl_sh = '0, sl_idx = '0, sl_tx = '0;
    logic       sl_ack = 1'b0, sl_rd = 1'b0;
    logic       pscl = 1'b1, psda = 1'b1;

    always @(negedge clk) begin
        logic scl_l, sda_m;
        scl_l = ~scl_oe_o;
        sda_m = ~sda_oe_o;
        if (rst_i) begin
            sl_mode = 0; sl_bit = 0; sl_byte = 0; slave_pull = 1'b0;
        end else if (pscl && scl_l && psda && !sda_m) begin
            bus_ev(sl_mode == 0 ? EV_S : EV_SR);
            sl_mode = 1; sl_bit = 0; sl_byte = 0; slave_pull = 1'b0;
        end else if (pscl && scl_l && !psda && sda_m) begin
            bus_ev(EV_P);
            sl_mode = 0; slave_pull = 1'b0;
        end else if (!pscl && scl_l) begin
            if (sl_mode == 1 && sl_bit < 8) begin
                sl_sh = {sl_sh[6:0], sda_line};
                sl_bit++;
            end else if (sl_mode == 2) begin
                sl_bit++;
                if (sl_bit == 9) begin
                    chk("mnack", sda_m, 1);
                    sl_mode = 3;
                end
            end
        end else if (pscl && !scl_l) begin
            case (sl_mode)
                1: begin
                    if (sl_bit == 8) begin
                        bus_ev(int'(sl_sh));
                        case (sl_byte)
                            0: begin sl_ack = (sl_sh[7:1] == SLV); sl_rd = sl_sh[0]; end
                            1: begin sl_idx = sl_sh; sl_ack = (sl_sh >= 8'h40 && sl_sh <= 8'h53); end
                            default: begin regs[sl_idx] = sl_sh; sl_ack = 1'b1; end
                        endcase
                        slave_pull = sl_ack;
                        sl_bit = 9;
                    end else if (sl_bit == 9) begin
                        slave_pull = 1'b0;
                        if (!sl_ack) begin
                            sl_mode = 3;
                        end else if (sl_byte == 0 && sl_rd) begin
                            sl_mode = 2;
                            sl_tx = regs[sl_idx];
                            sl_bit = 0;
                            slave_pull = ~sl_tx[7];
                        end else begin
                            sl_bit = 0;
                            sl_byte++;
                        end
                    end
                end
                2: begin
                    if (sl_bit >= 1 && sl_bit < 8) slave_pull = ~sl_tx[7 - sl_bit];
                    else if (sl_bit == 8)         slave_pull = 1'b0;
                end
                default: ;
            endcase
        end
        pscl = scl_l;
        psda = sda_m;
    end

    always @(negedge clk) begin
        res_t r;
        if (done_o) begin
            done_cnt++;
            chk("res_q_empty", res_q.size() == 0, 0);
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                chk("latency", cyc - r.acc, r.lat);
                chk("ack_err", ack_err_o, r.ack);
                chk("rdata", rdata_o, r.rd);
            end
        end
    end

    task automatic push_ev4(input int a, input int b, input int c, input int d);
        ev_q.push_back(a); ev_q.push_back(b);
        if (c >= 0) ev_q.push_back(c);
        if (d >= 0) ev_q.push_back(d);
    endtask

    // Called at a negedge; slots counts START and STOP as one slot each.
    task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] idx,
                         input logic [7:0] wd, input int slots, input logic ack,
                         input logic [7:0] rd);
        res_t r;
        rw_i = rw; dev_addr_i = a; index_i = idx; wdata_i = wd; start_i = 1'b1;
        #1 chk("busy_acc", busy_o, 1);
        r.lat = 4 * slots * int'(DIV) + 1;
        r.ack = ack; r.rd = rd; r.acc = cyc;
        res_q.push_back(r);
        accepted++;
        @(negedge clk);
        start_i = 1'b0;
        #1 chk("ack_clr", ack_err_o, 0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) return;
        end
        chk("done_timeout", done_o, 1);
    endtask

    initial begin
        int snap;
        for (int unsigned i = 0; i < 256; i++) regs[i] = '0;
        regs[8'h40] = 8'h3C;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", scl_oe_o, 0);
        chk("rst_sda_oe", sda_oe_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ack_err", ack_err_o, 0);
        chk("rst_rdata", rdata_o, 8'h00);
        chk("rst_scl_out", scl_out_o, 0);
        chk("rst_sda_out", sda_out_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // write 0x72 / 0x45 / 0xA5 with an ignored mid-transfer start
        push_ev4(EV_S, 8'hE4, 8'h45, 8'hA5); ev_q.push_back(EV_P);
        issue(1'b0, 7'h72, 8'h45, 8'hA5, 29, 1'b0, 8'h00);
        repeat (200) @(negedge clk);
        start_i = 1'b1; rw_i = 1'b1; dev_addr_i = 7'h10;
        #1 chk("busy_mid", busy_o, 1);
        @(negedge clk);
        start_i = 1'b0;
        wait_done(1000);

        // start on the done cycle is ignored; the one in the next cycle is accepted
        push_ev4(EV_S, 8'hE4, 8'h40, EV_SR); ev_q.push_back(8'hE5); ev_q.push_back(EV_P);
        rw_i = 1'b1; dev_addr_i = 7'h72; index_i = 8'h40; start_i = 1'b1;
        #1 chk("busy_done", busy_o, 1);
        @(negedge clk);
        issue(1'b1, 7'h72, 8'h40, 8'h00, 39, 1'b0, 8'h3C);
        wait_done(1000);
        repeat (2) @(negedge clk);
        #1 chk("busy_idle", busy_o, 0);

        // read back the register written above
        push_ev4(EV_S, 8'hE4, 8'h45, EV_SR); ev_q.push_back(8'hE5); ev_q.push_back(EV_P);
        issue(1'b1, 7'h72, 8'h45, 8'h00, 39, 1'b0, 8'hA5);
        wait_done(1000);
        repeat (2) @(negedge clk);

        // write to absent address 0x10: abort after first ack slot
        push_ev4(EV_S, 8'h20, EV_P, -1);
        issue(1'b0, 7'h10, 8'h45, 8'h11, 11, 1'b1, 8'hA5);
        wait_done(1000);
        repeat (5) @(negedge clk);
        chk("ack_hold", ack_err_o, 1);
        chk("rdata_hold", rdata_o, 8'hA5);

        // read with index 0x99 NACKed: no Sr, STOP after slot 18
        push_ev4(EV_S, 8'hE4, 8'h99, EV_P);
        issue(1'b1, 7'h72, 8'h99, 8'h00, 20, 1'b1, 8'hA5);
        wait_done(1000);
        repeat (2) @(negedge clk);

        // reset during the second byte, while SCL is held low
        push_ev4(EV_S, 8'hE4, 8'h50, 8'h5A); ev_q.push_back(EV_P);
        issue(1'b0, 7'h72, 8'h50, 8'h5A, 29, 1'b0, 8'h00);
        repeat (220) @(negedge clk);
        for (int i = 0; i < 50 && !scl_oe_o; i++) @(negedge clk);
        chk("pre_rst_scl", scl_oe_o, 1);
        snap = done_cnt;
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        chk("mrst_scl_oe", scl_oe_o, 0);
        chk("mrst_sda_oe", sda_oe_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        ev_q.delete();
        res_q.delete();
        accepted--;
        @(negedge clk);
        #1 rst_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("mrst_no_done", done_cnt, snap);
        chk("mrst_rdata", rdata_o, 8'h00);

        // clean write then read back after reset
        push_ev4(EV_S, 8'hE4, 8'h41, 8'h77); ev_q.push_back(EV_P);
        issue(1'b0, 7'h72, 8'h41, 8'h77, 29, 1'b0, 8'h00);
        wait_done(1000);
        repeat (2) @(negedge clk);
        push_ev4(EV_S, 8'hE4, 8'h41, EV_SR); ev_q.push_back(8'hE5); ev_q.push_back(EV_P);
        issue(1'b1, 7'h72, 8'h41, 8'h00, 39, 1'b0, 8'h77);
        wait_done(1000);
        repeat (20) @(negedge clk);

        chk("ev_left", ev_q.size(), 0);
        chk("res_left", res_q.size(), 0);
        chk("done_count", done_cnt, accepted);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
